ibuf_fifo: RTL

IBUF_FIFO -- requirements
Module: ibuf_fifo

---
 rtl/ibuf_fifo_pkg.sv | 12 +
 rtl/ibuf_mem.sv | 26 ++
 rtl/ibuf_fifo.sv | 97 +++++++++
 3 files changed

// File: rtl/ibuf_fifo_pkg.sv
// rtl/ibuf_fifo_pkg.sv - shared flit width and pointer sizing helper for mesh input buffers
package ibuf_fifo_pkg;

   // Width of one flit payload across the mesh
   localparam int FLIT_W = 1;

   // Pointer width for a buffer of the given depth; never narrower than one bit
   function automatic int ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/ibuf_mem.sv
// rtl/ibuf_mem.sv - DEPTH x WIDTH register array, one write port, async read, no reset
module ibuf_mem #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic             clk,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [WIDTH-1:0] rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   // Storage is deliberately left unreset; validity is tracked by the occupancy count
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ibuf_fifo.sv
// rtl/ibuf_fifo.sv - router input buffer FIFO with flush and almost-full flag
module ibuf_fifo
   import ibuf_fifo_pkg::*;
#(
   parameter int PYLD_W   = FLIT_W,
   parameter int DEPTH    = 4,
   parameter int AFULL_TH = DEPTH - 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   flush_i,
   input  logic                   valid_i,
   output logic                   ready_o,
   input  logic [PYLD_W-1:0]      payload_i,
   output logic                   valid_o,
   input  logic                   ready_i,
   output logic [PYLD_W-1:0]      payload_o,
   output logic [$clog2(DEPTH):0] count_o,
   output logic                   afull_o
);

   localparam int PW = ptr_w(DEPTH);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
   localparam logic [CW-1:0] AFULL_CNT = CW'(AFULL_TH);

   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          full;
   logic          empty;
   logic          push;
   logic          pop;

   // Handshake flags come only from the registered count, so ready/valid never
   // depend combinationally on the opposite side of the link
   assign full  = (count_q == FULL_CNT);
   assign empty = (count_q == '0);
   assign push  = valid_i & ~full  & ~flush_i;
   assign pop   = ~empty & ready_i & ~flush_i;

   assign ready_o = ~full;
   assign valid_o = ~empty;
   assign count_o = count_q;
   assign afull_o = (count_q >= AFULL_CNT);

   // Next pointers and occupancy; flush wins over any transfer in the same cycle
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         if (push && !pop) begin
            count_d = count_q + CW'(1);
         end else if (pop && !push) begin
            count_d = count_q - CW'(1);
         end
      end
   end

   // Pointer and count registers; reset empties the buffer immediately
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   ibuf_mem #(
      .WIDTH (PYLD_W),
      .DEPTH (DEPTH),
      .AW    (PW)
   ) u_mem (
      .clk     (clk),
      .we_i    (push),
      .waddr_i (wr_ptr_q),
      .wdata_i (payload_i),
      .raddr_i (rd_ptr_q),
      .rdata_o (payload_o)
   );

endmodule
